ps2_tx_ctrl: RTL and testbench
==============================

PS2_TX_CTRL -- requirements
Module: ps2_tx_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named Clk and Reset.
REQ-002 Parameter INHIBIT_CYCLES, default 5000, SHALL set the clock-inhibit hold time in Clk cycles (100 us at 50 MHz).
REQ-003 Parameter TIMEOUT_CYCLES, default 750000, SHALL set the per-edge device-response watchdog in Clk cycles (15 ms at 50 MHz).
REQ-004 Clk  in  1  system clock; all logic is on its rising edge.
REQ-005 Reset  in  1  synchronous active-high reset.
REQ-006 Start  in  1  single-cycle request to transmit TxByte.
REQ-007 TxByte  in  8  byte to send; captured on the accepted Start.
REQ-008 Busy  out  1  high from the cycle after acceptance until return to IDLE.
REQ-009 Done  out  1  one-cycle pulse: frame sent and device ACK seen.
REQ-010 Error  out  1  one-cycle pulse: timeout, or ACK bit sampled high.
REQ-011 Ps2ClkIn, Ps2DataIn  in  1 each  raw, asynchronous PS/2 line levels.
REQ-012 Ps2ClkOe, Ps2DataOe  out  1 each  high means drive the line low (open-drain enable).

Function
REQ-013 Frame layout SHALL be an 11-bit vector: bit0 start=0, bits1-8 TxByte LSB first, bit9 odd parity (XNOR-reduce of TxByte), bit10 stop=1.
REQ-014 Ps2ClkIn and Ps2DataIn SHALL pass through 2-FF synchronizers; a falling edge is synchronized clock 1 then 0 on consecutive cycles.
REQ-015 FSM states SHALL be IDLE, INHIBIT, REQ, SHIFT, ACK, RELEASE.
REQ-016 IDLE: Start=1 SHALL capture the frame, clear the bit index and counter, and enter INHIBIT; Busy rises the next cycle.
REQ-017 Start SHALL be ignored in every state other than IDLE.
REQ-018 INHIBIT: Ps2ClkOe=1 and Ps2DataOe=0 SHALL hold for exactly INHIBIT_CYCLES cycles, then the FSM enters REQ.
REQ-019 REQ: Ps2DataOe=1 (start bit) and Ps2ClkOe=0 SHALL hold; the first falling edge sets the bit index to 1, drives frame bit 1, and enters SHIFT.
REQ-020 SHIFT: each falling edge SHALL increment the bit index and drive Ps2DataOe = NOT frame[index]; after index 10 (stop, released) the next falling edge enters ACK handling.
REQ-021 ACK: Ps2DataIn (synchronized) SHALL be sampled on the 11th falling edge; 0 enters RELEASE, 1 pulses Error and enters IDLE.
REQ-022 RELEASE: the FSM SHALL wait until both synchronized lines are high, then pulse Done and enter IDLE.
REQ-023 The watchdog SHALL restart on entry to REQ and on every falling edge; reaching TIMEOUT_CYCLES in REQ, SHIFT, ACK or RELEASE SHALL pulse Error, release both lines, and enter IDLE.
REQ-024 Both Oe outputs SHALL be 0 in IDLE, and Ps2ClkOe SHALL be 0 in every state except INHIBIT.
REQ-025 Done and Error SHALL never assert in the same cycle; Busy SHALL be 0 in the cycle Done or Error pulses.
REQ-026 The cycle counter SHALL be wide enough for max(INHIBIT_CYCLES, TIMEOUT_CYCLES) (20 bits at the defaults), and the bit index SHALL be 4 bits and never exceed 11.

Reset
REQ-027 Reset SHALL force IDLE, Busy=0, Done=0, Error=0, Ps2ClkOe=0, Ps2DataOe=0, clear the counter, bit index and frame register, and set the synchronizer flops to 1.
REQ-028 Reset mid-frame SHALL release both lines in the following cycle with no Done or Error pulse.

Structure
REQ-029 Package ps2_pkg SHALL hold the state enumeration, the frame bit positions (START=0, PARITY=9, STOP=10, FRAME_LEN=11), and the frame-build/parity function.
REQ-030 Sub-module ps2_line_sync SHALL provide the 2-FF synchronizer plus the falling-edge pulse, and is instantiated once for the clock line and once for the data line.

Verification
REQ-031 TxByte=0xF4, device model clocks 11 edges with ACK low -> data line carries 0,0,0,1,0,1,1,1,1,0,1 then ACK; Done pulses once; Error stays 0.
REQ-032 TxByte=0x00, then 0xFF -> parity bit 1 for both; Ps2ClkOe stays high for exactly 5000 cycles before each frame.
REQ-033 Device never clocks after REQ -> Error pulses exactly 750000 cycles after entering REQ; both Oe are 0 the next cycle.
REQ-034 Device ACK bit held high on edge 11 -> Error pulses and Done does not.
REQ-035 Reset asserted after edge 5 -> next cycle Oe=0, Busy=0, no pulses; a following Start=1 with TxByte=0xAA completes normally.
REQ-036 Start pulses while Busy -> ignored; the in-flight byte is unchanged on the line.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, frame layout and frame builder for the PS/2 host transmitter.
`timescale 1ns/1ps
`default_nettype none

package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_REQ     = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_ACK     = 3'd4,
    ST_RELEASE = 3'd5
  } ps2_state_e;

  localparam int START     = 0;
  localparam int PARITY    = 9;
  localparam int STOP      = 10;
  localparam int FRAME_LEN = 11;

  // Odd parity: the parity bit makes the total count of ones in data+parity odd.
  function automatic logic [FRAME_LEN-1:0] build_frame(input logic [7:0] data);
    logic [FRAME_LEN-1:0] f;
    f          = '0;
    f[START]   = 1'b0;
    f[8:1]     = data;
    f[PARITY]  = ~^data;
    f[STOP]    = 1'b1;
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizer for one raw PS/2 line plus a one-cycle falling-edge pulse.
`timescale 1ns/1ps
`default_nettype none

module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_sync,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Idle PS/2 lines float high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= line_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign line_sync = sync;
  assign fall      = prev & ~sync;

endmodule

`default_nettype wire

// File: rtl/ps2_tx_ctrl.sv
// ps2_tx_ctrl: PS/2 host-to-device byte transmitter (inhibit, request-to-send, shift, ACK, release).
`timescale 1ns/1ps
`default_nettype none

module ps2_tx_ctrl
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] TxByte,
  output logic       Busy,
  output logic       Done,
  output logic       Error,
  input  logic       Ps2ClkIn,
  input  logic       Ps2DataIn,
  output logic       Ps2ClkOe,
  output logic       Ps2DataOe
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  ps2_state_e             state;
  ps2_state_e             state_next;
  logic [CNT_W-1:0]       cnt;
  logic [3:0]             idx;
  logic [FRAME_LEN-1:0]   frame;

  logic clk_sync;
  logic clk_fall;
  logic data_sync;
  logic unused_data_fall;

  logic inhibit_done;
  logic timeout;
  logic done_set;
  logic error_set;

  ps2_line_sync u_clk_sync (
    .clk       (Clk),
    .rst       (Reset),
    .line_in   (Ps2ClkIn),
    .line_sync (clk_sync),
    .fall      (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk       (Clk),
    .rst       (Reset),
    .line_in   (Ps2DataIn),
    .line_sync (data_sync),
    .fall      (unused_data_fall)
  );

  assign inhibit_done = (cnt == CNT_W'(INHIBIT_CYCLES - 1));
  assign timeout      = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (Start) state_next = ST_INHIBIT;
      ST_INHIBIT: if (inhibit_done) state_next = ST_REQ;
      ST_REQ: begin
        if (clk_fall)       state_next = ST_SHIFT;
        else if (error_set) state_next = ST_IDLE;
      end
      // Reaching the parity index hands the stop bit and ACK edge to ST_ACK.
      ST_SHIFT: begin
        if (clk_fall && (idx == 4'(PARITY))) state_next = ST_ACK;
        else if (error_set)                   state_next = ST_IDLE;
      end
      ST_ACK: begin
        if (clk_fall)       state_next = data_sync ? ST_IDLE : ST_RELEASE;
        else if (error_set) state_next = ST_IDLE;
      end
      ST_RELEASE: if (done_set || error_set) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy      = (state != ST_IDLE);
    Ps2ClkOe  = (state == ST_INHIBIT);
    Ps2DataOe = 1'b0;
    done_set  = 1'b0;
    error_set = 1'b0;
    case (state)
      ST_REQ: begin
        Ps2DataOe = 1'b1;
        error_set = timeout && !clk_fall;
      end
      ST_SHIFT: begin
        Ps2DataOe = ~frame[idx];
        error_set = timeout && !clk_fall;
      end
      ST_ACK: begin
        error_set = clk_fall ? data_sync : timeout;
      end
      ST_RELEASE: begin
        done_set  = clk_sync && data_sync;
        error_set = timeout && !done_set;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt   <= '0;
      idx   <= '0;
      frame <= '0;
      Done  <= 1'b0;
      Error <= 1'b0;
    end else begin
      Done  <= done_set;
      Error <= error_set;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            frame <= build_frame(TxByte);
            idx   <= '0;
            cnt   <= '0;
          end
        end
        ST_INHIBIT: cnt <= inhibit_done ? '0 : cnt + CNT_W'(1);
        default: begin
          // Watchdog restarts on every device clock edge.
          cnt <= clk_fall ? '0 : cnt + CNT_W'(1);
          if (clk_fall && ((state == ST_REQ) || (state == ST_SHIFT))) begin
            idx <= idx + 4'd1;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ps2_tx_ctrl.sv
// tb_ps2_tx_ctrl: scoreboard bench with an open-drain PS/2 device model driving directed frames.
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_tx_ctrl;

  localparam int INH  = 5000;
  localparam int TMO  = 3000;
  localparam int HALF = 20;

  typedef struct packed {
    logic [10:0] bits;
    logic        check_bits;
    logic        exp_done;
    int          id;
  } exp_t;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] TxByte = 8'h00;
  logic       Busy, Done, Error, Ps2ClkOe, Ps2DataOe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       clk_line, data_line;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          inh_cnt = 0;
  int          inh_len = 0;
  logic [10:0] dev_bits = '0;
  exp_t        exp_q[$];
  exp_t        mon_e;

  assign clk_line  = dev_clk  & ~Ps2ClkOe;
  assign data_line = dev_data & ~Ps2DataOe;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ps2_tx_ctrl #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .Clk       (clk),
    .Reset     (Reset),
    .Start     (Start),
    .TxByte    (TxByte),
    .Busy      (Busy),
    .Done      (Done),
    .Error     (Error),
    .Ps2ClkIn  (clk_line),
    .Ps2DataIn (data_line),
    .Ps2ClkOe  (Ps2ClkOe),
    .Ps2DataOe (Ps2DataOe)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Length of the most recent clock-inhibit window.
  always @(negedge clk) begin
    if (Ps2ClkOe) inh_cnt++;
    else if (inh_cnt != 0) begin
      inh_len = inh_cnt;
      inh_cnt = 0;
    end
  end

  // Scoreboard monitor: every Done/Error pulse consumes one expected outcome.
  always @(negedge clk) begin
    if (!Reset && (Done || Error)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'b0, Done, Error}, 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("outcome_%0d", mon_e.id), {30'b0, Done, Error},
              mon_e.exp_done ? 32'h2 : 32'h1);
        check($sformatf("busy_at_pulse_%0d", mon_e.id), {31'b0, Busy}, 32'h0);
        if (mon_e.check_bits)
          check($sformatf("frame_bits_%0d", mon_e.id), {21'b0, dev_bits}, {21'b0, mon_e.bits});
      end
    end
  end

  task automatic issue(input logic [7:0] b, input logic push, input logic [10:0] bits,
                       input logic chk_bits, input logic exp_done, input int id);
    exp_t e;
    e.bits       = bits;
    e.check_bits = chk_bits;
    e.exp_done   = exp_done;
    e.id         = id;
    @(negedge clk);
    TxByte = b;
    Start  = 1'b1;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    Start  = 1'b0;
    TxByte = 8'h3C;
    check("busy_after_start", {31'b0, Busy}, 32'h1);
  endtask

  task automatic pulse_start(input logic [7:0] b);
    @(negedge clk);
    TxByte = b;
    Start  = 1'b1;
    @(negedge clk);
    Start  = 1'b0;
  endtask

  task automatic wait_req(output int t);
    logic found;
    found = 1'b0;
    t = 0;
    for (int i = 0; i < INH + 200 && !found; i++) begin
      @(negedge clk);
      if (Ps2DataOe) begin
        found = 1'b1;
        t = cyc;
      end
    end
    check("req_reached", {31'b0, found}, 32'h1);
    @(negedge clk);
    check("inhibit_len", inh_len, INH);
    check("lines_in_req", {30'b0, Ps2ClkOe, Ps2DataOe}, 32'h1);
  endtask

  // Device clocks n_edges falling edges; before edge k+1 it samples bit k of the frame.
  task automatic device_frame(input int n_edges, input logic ack_high);
    logic [10:0] b;
    b = '0;
    for (int k = 0; k < n_edges; k++) begin
      repeat (HALF) @(negedge clk);
      b[k] = data_line;
      dev_bits = b;
      if (k == 10) dev_data = ack_high;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    dev_data = 1'b1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
    check("pulse_seen", exp_q.size(), 32'h0);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int t_req;
    int t_err;
    logic got_err;

    repeat (5) @(negedge clk);
    check("reset_outputs", {27'b0, Busy, Done, Error, Ps2ClkOe, Ps2DataOe}, 32'h0);
    Reset = 1'b0;
    repeat (3) @(negedge clk);

    // 0xF4 with ACK low
    issue(8'hF4, 1'b1, 11'b10111101000, 1'b1, 1'b1, 1);
    wait_req(t_req);
    device_frame(11, 1'b0);
    wait_drain();

    // 0x00 with Start pulses while busy
    issue(8'h00, 1'b1, 11'b11000000000, 1'b1, 1'b1, 2);
    repeat (50) @(negedge clk);
    pulse_start(8'hC3);
    wait_req(t_req);
    pulse_start(8'h5F);
    device_frame(11, 1'b0);
    wait_drain();

    // 0xFF
    issue(8'hFF, 1'b1, 11'b11111111110, 1'b1, 1'b1, 3);
    wait_req(t_req);
    device_frame(11, 1'b0);
    wait_drain();

    // Device never clocks: watchdog timeout
    issue(8'h12, 1'b1, 11'b0, 1'b0, 1'b0, 4);
    wait_req(t_req);
    got_err = 1'b0;
    t_err = 0;
    for (int i = 0; i < TMO + 100 && !got_err; i++) begin
      @(negedge clk);
      if (Error) begin
        got_err = 1'b1;
        t_err = cyc;
      end
    end
    check("timeout_seen", {31'b0, got_err}, 32'h1);
    check("timeout_latency", t_err - t_req, TMO);
    @(negedge clk);
    check("lines_after_timeout", {29'b0, Busy, Ps2ClkOe, Ps2DataOe}, 32'h0);
    wait_drain();

    // ACK held high
    issue(8'h5A, 1'b1, 11'b11010110100, 1'b1, 1'b0, 5);
    wait_req(t_req);
    device_frame(11, 1'b1);
    wait_drain();

    // Reset after edge 5, no outcome expected
    issue(8'h81, 1'b0, 11'b0, 1'b0, 1'b0, 6);
    wait_req(t_req);
    device_frame(5, 1'b0);
    check("midframe_busy", {31'b0, Busy}, 32'h1);
    Reset = 1'b1;
    @(negedge clk);
    check("reset_midframe", {27'b0, Busy, Done, Error, Ps2ClkOe, Ps2DataOe}, 32'h0);
    Reset = 1'b0;
    repeat (100) @(negedge clk);
    check("idle_after_reset", {29'b0, Busy, Ps2ClkOe, Ps2DataOe}, 32'h0);

    // 0xAA completes normally after the reset
    issue(8'hAA, 1'b1, 11'b11101010100, 1'b1, 1'b1, 7);
    wait_req(t_req);
    device_frame(11, 1'b0);
    wait_drain();

    repeat (50) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
